// File: rtl/branch_tracker.sv
// In-flight branch queue: tracks predicted branches from fetch to in-order commit,
// pulses predictor updates and PC redirects. Define BRANCH_TRACKER_STATS_EN for a mispredict counter.
module branch_tracker #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  alloc_en,
    input  logic                  alloc_pred,
    input  logic [ADDR_WIDTH-1:0] alloc_alt_pc,
    output logic                  alloc_ready,
    output logic [DEPTH_LOG2-1:0] alloc_tag,
    input  logic                  resolve_en,
    input  logic [DEPTH_LOG2-1:0] resolve_tag,
    input  logic                  resolve_taken,
    output logic                  modify_en,
    output logic                  clear,
    output logic                  choice,
    output logic                  redirect_en,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [15:0]           mispredict_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t                  r_state, w_state_nxt;
    logic [DEPTH-1:0]        r_valid, r_resolved, r_pred, r_taken;
    logic [ADDR_WIDTH-1:0]   r_alt_pc [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_head, r_tail;
    logic [DEPTH_LOG2:0]     r_count;
    logic                    r_modify_en, r_clear, r_choice, r_redirect_en;
    logic [ADDR_WIDTH-1:0]   r_redirect_pc;

    logic w_commit, w_mispred, w_alloc, w_resolve;

    // Commit looks only at registered flags, so a resolve never commits in its own cycle.
    assign w_commit  = (r_state == RUN) && r_valid[r_head] && r_resolved[r_head];
    assign w_mispred = w_commit && (r_taken[r_head] != r_pred[r_head]);
    assign w_alloc   = alloc_en && alloc_ready && !w_mispred;
    assign w_resolve = resolve_en && (r_state == RUN) && r_valid[resolve_tag]
                       && !r_resolved[resolve_tag] && !w_mispred;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= RUN;
        else if (rdy)
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_mispred) w_state_nxt = FLUSH;
            FLUSH:   w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        alloc_ready = 1'b0;
        if (r_state == RUN && r_count < CNT_FULL)
            alloc_ready = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= '0;
            r_resolved    <= '0;
            r_pred        <= '0;
            r_taken       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_modify_en   <= 1'b0;
            r_clear       <= 1'b0;
            r_choice      <= 1'b0;
            r_redirect_en <= 1'b0;
            r_redirect_pc <= '0;
        end else if (!rdy) begin
            r_modify_en   <= 1'b0;
            r_clear       <= 1'b0;
            r_choice      <= 1'b0;
            r_redirect_en <= 1'b0;
        end else begin
            r_modify_en   <= w_commit;
            r_clear       <= w_mispred;
            r_choice      <= w_commit && r_taken[r_head];
            r_redirect_en <= w_mispred;
            if (w_mispred) begin
                r_redirect_pc <= r_alt_pc[r_head];
                r_valid       <= '0;
                r_head        <= '0;
                r_tail        <= '0;
                r_count       <= '0;
            end else begin
                // Tail and head never alias here: tail==head implies empty (no commit) or full (no alloc).
                if (w_alloc) begin
                    r_valid[r_tail]    <= 1'b1;
                    r_resolved[r_tail] <= 1'b0;
                    r_pred[r_tail]     <= alloc_pred;
                    r_taken[r_tail]    <= 1'b0;
                    r_alt_pc[r_tail]   <= alloc_alt_pc;
                    r_tail             <= r_tail + PTR_ONE;
                end
                if (w_resolve) begin
                    r_resolved[resolve_tag] <= 1'b1;
                    r_taken[resolve_tag]    <= resolve_taken;
                end
                if (w_commit) begin
                    r_valid[r_head] <= 1'b0;
                    r_head          <= r_head + PTR_ONE;
                end
                case ({w_alloc, w_commit})
                    2'b10:   r_count <= r_count + CNT_ONE;
                    2'b01:   r_count <= r_count - CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign alloc_tag   = r_tail;
    assign modify_en   = r_modify_en;
    assign clear       = r_clear;
    assign choice      = r_choice;
    assign redirect_en = r_redirect_en;
    assign redirect_pc = r_redirect_pc;

`ifdef BRANCH_TRACKER_STATS_EN
    logic [15:0] r_mispredict_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_mispredict_cnt <= '0;
        else if (rdy && w_mispred && r_mispredict_cnt != 16'hFFFF)
            r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
    end

    assign mispredict_cnt = r_mispredict_cnt;
`else
    assign mispredict_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_branch_tracker.sv
// Bench for branch_tracker: directed vector table, hand sequences for multi-cycle
// corners, then randomized traffic against a queue-level reference model.
module tb_branch_tracker;
    localparam int AW = 32;
    localparam int DL = 3;
    localparam int D  = 8;
`ifdef BRANCH_TRACKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, rdy, alloc_en, alloc_pred, resolve_en, resolve_taken;
    logic [AW-1:0] alloc_alt_pc;
    logic [DL-1:0] resolve_tag, alloc_tag;
    logic          alloc_ready, modify_en, clear, choice, redirect_en;
    logic [AW-1:0] redirect_pc;
    logic [15:0]   mispredict_cnt;

    branch_tracker #(.ADDR_WIDTH(AW), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_en(alloc_en), .alloc_pred(alloc_pred), .alloc_alt_pc(alloc_alt_pc),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .resolve_en(resolve_en), .resolve_tag(resolve_tag), .resolve_taken(resolve_taken),
        .modify_en(modify_en), .clear(clear), .choice(choice),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: plain queue of branch records indexed modulo depth.
    bit            m_v[D], m_r[D], m_p[D], m_t[D];
    logic [AW-1:0] m_a[D];
    int            m_head, m_tail, m_count, m_cnt;
    bit            m_flush;
    bit            e_mod, e_clr, e_cho, e_red;
    logic [AW-1:0] e_pc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_step(input bit rs, input bit rv, input bit ae, input bit ap,
                              input logic [AW-1:0] aa, input bit re, input int rt, input bit rk);
        bit ready, commit, mis, ok_res;
        if (rs) begin
            for (int i = 0; i < D; i++) begin m_v[i] = 0; m_r[i] = 0; end
            m_head = 0; m_tail = 0; m_count = 0; m_flush = 0; m_cnt = 0;
            e_mod = 0; e_clr = 0; e_cho = 0; e_red = 0; e_pc = '0;
            return;
        end
        e_mod = 0; e_clr = 0; e_cho = 0; e_red = 0;
        if (!rv) return;
        if (m_flush) begin
            m_flush = 0;
            return;
        end
        ready  = m_count < D;
        commit = m_v[m_head] && m_r[m_head];
        mis    = commit && (m_t[m_head] != m_p[m_head]);
        e_mod  = commit;
        e_clr  = mis;
        e_cho  = commit && m_t[m_head];
        e_red  = mis;
        if (mis) begin
            e_pc = m_a[m_head];
            for (int i = 0; i < D; i++) m_v[i] = 0;
            m_head = 0; m_tail = 0; m_count = 0; m_flush = 1;
            if (STATS && m_cnt < 65535) m_cnt++;
            return;
        end
        ok_res = re && m_v[rt] && !m_r[rt];
        if (commit) begin
            m_v[m_head] = 0;
            m_head = (m_head + 1) % D;
            m_count--;
        end
        if (ok_res) begin
            m_r[rt] = 1;
            m_t[rt] = rk;
        end
        if (ae && ready) begin
            m_v[m_tail] = 1; m_r[m_tail] = 0; m_p[m_tail] = ap; m_a[m_tail] = aa;
            m_tail = (m_tail + 1) % D;
            m_count++;
        end
    endtask

    task automatic cycle(input bit rs, input bit rv, input bit ae, input bit ap,
                         input logic [AW-1:0] aa, input bit re, input int rt, input bit rk,
                         input bit cmp);
        rst = rs; rdy = rv; alloc_en = ae; alloc_pred = ap; alloc_alt_pc = aa;
        resolve_en = re; resolve_tag = rt[DL-1:0]; resolve_taken = rk;
        if (cmp && !rs) begin
            chk("alloc_ready", 64'(alloc_ready), 64'(!m_flush && m_count < D));
            chk("alloc_tag", 64'(alloc_tag), 64'(m_tail));
        end
        model_step(rs, rv, ae, ap, aa, re, rt, rk);
        @(posedge clk);
        #1;
        if (cmp) begin
            chk("modify_en", 64'(modify_en), 64'(e_mod));
            chk("clear", 64'(clear), 64'(e_clr));
            chk("redirect_en", 64'(redirect_en), 64'(e_red));
            if (e_mod) chk("choice", 64'(choice), 64'(e_cho));
            if (e_red) chk("redirect_pc", 64'(redirect_pc), 64'(e_pc));
            chk("mispredict_cnt", 64'(mispredict_cnt), 64'(m_cnt));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, '0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        cycle(1, 1, 0, 0, '0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, '0, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit            ae, ap, re, rk;
        logic [AW-1:0] aa;
        int            rt;
        bit            x_rdy;
        int            x_tag;
        bit            x_mod, x_clr, x_cho, x_red;
        logic [AW-1:0] x_pc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        //         ae ap re rk  aa         rt rdy tag mod clr cho red pc
        tbl[0] = '{1, 1, 0, 0, 32'h40,  0, 1, 0, 0, 0, 0, 0, 32'h0};
        tbl[1] = '{0, 0, 1, 1, 32'h0,   0, 1, 1, 0, 0, 0, 0, 32'h0};
        tbl[2] = '{0, 0, 0, 0, 32'h0,   0, 1, 1, 1, 0, 1, 0, 32'h0};
        tbl[3] = '{1, 1, 0, 0, 32'h100, 0, 1, 1, 0, 0, 0, 0, 32'h0};
        tbl[4] = '{0, 0, 1, 0, 32'h0,   1, 1, 2, 0, 0, 0, 0, 32'h0};
        tbl[5] = '{0, 0, 0, 0, 32'h0,   0, 1, 2, 1, 1, 0, 1, 32'h100};
        tbl[6] = '{0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 32'h0};
        tbl[7] = '{1, 0, 0, 0, 32'h77,  0, 1, 0, 0, 0, 0, 0, 32'h0};
        tbl[8] = '{0, 0, 1, 0, 32'h0,   0, 1, 1, 0, 0, 0, 0, 32'h0};
        tbl[9] = '{0, 0, 0, 0, 32'h0,   0, 1, 1, 1, 0, 0, 0, 32'h0};

        rst = 1; rdy = 0; alloc_en = 0; alloc_pred = 0; alloc_alt_pc = '0;
        resolve_en = 0; resolve_tag = '0; resolve_taken = 0;
        do_reset();
        chk("rst alloc_ready", 64'(alloc_ready), 64'(1));
        chk("rst alloc_tag", 64'(alloc_tag), 64'(0));
        chk("rst modify_en", 64'(modify_en), 64'(0));
        chk("rst clear", 64'(clear), 64'(0));
        chk("rst choice", 64'(choice), 64'(0));
        chk("rst redirect_en", 64'(redirect_en), 64'(0));
        chk("rst redirect_pc", 64'(redirect_pc), 64'(0));
        chk("rst mispredict_cnt", 64'(mispredict_cnt), 64'(0));

        for (int i = 0; i < 10; i++) begin
            chk($sformatf("vec%0d alloc_ready", i), 64'(alloc_ready), 64'(tbl[i].x_rdy));
            chk($sformatf("vec%0d alloc_tag", i), 64'(alloc_tag), 64'(tbl[i].x_tag));
            cycle(0, 1, tbl[i].ae, tbl[i].ap, tbl[i].aa, tbl[i].re, tbl[i].rt, tbl[i].rk, 0);
            chk($sformatf("vec%0d modify_en", i), 64'(modify_en), 64'(tbl[i].x_mod));
            chk($sformatf("vec%0d clear", i), 64'(clear), 64'(tbl[i].x_clr));
            chk($sformatf("vec%0d redirect_en", i), 64'(redirect_en), 64'(tbl[i].x_red));
            if (tbl[i].x_mod) chk($sformatf("vec%0d choice", i), 64'(choice), 64'(tbl[i].x_cho));
            if (tbl[i].x_red) chk($sformatf("vec%0d redirect_pc", i), 64'(redirect_pc), 64'(tbl[i].x_pc));
        end

        // Fill, overflow attempt, commit head, wrap to tag 0.
        do_reset();
        for (int i = 0; i < D; i++) begin
            chk("fill tag", 64'(alloc_tag), 64'(i));
            cycle(0, 1, 1, 1, 32'h200 + 32'(i), 0, 0, 0, 1);
        end
        chk("full alloc_ready", 64'(alloc_ready), 64'(0));
        cycle(0, 1, 1, 0, 32'hDEAD, 0, 0, 0, 1);
        chk("full ignored tag", 64'(alloc_tag), 64'(0));
        cycle(0, 1, 0, 0, '0, 1, 0, 1, 1);
        chk("full before commit", 64'(alloc_ready), 64'(0));
        cycle(0, 1, 0, 0, '0, 0, 0, 0, 1);
        chk("wrap modify_en", 64'(modify_en), 64'(1));
        chk("wrap alloc_ready", 64'(alloc_ready), 64'(1));
        chk("wrap alloc_tag", 64'(alloc_tag), 64'(0));
        cycle(0, 1, 1, 0, 32'h300, 0, 0, 0, 1);
        chk("after wrap tag", 64'(alloc_tag), 64'(1));

        // Out-of-order resolve: younger first holds commit until head resolves.
        do_reset();
        cycle(0, 1, 1, 0, 32'h10, 0, 0, 0, 1);
        cycle(0, 1, 1, 0, 32'h20, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, '0, 1, 1, 0, 1);
        idle(2);
        chk("ooo no commit", 64'(modify_en), 64'(0));
        cycle(0, 1, 0, 0, '0, 1, 0, 0, 1);
        cycle(0, 1, 0, 0, '0, 0, 0, 0, 1);
        chk("ooo commit tag0", 64'(modify_en), 64'(1));
        cycle(0, 1, 0, 0, '0, 0, 0, 0, 1);
        chk("ooo commit tag1", 64'(modify_en), 64'(1));
        cycle(0, 1, 0, 0, '0, 0, 0, 0, 1);
        chk("ooo drained", 64'(modify_en), 64'(0));

        // rdy low freezes a pending commit.
        do_reset();
        cycle(0, 1, 1, 1, 32'h44, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, '0, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 0, 32'h55, 0, 0, 0, 1);
            chk("stall no pulse", 64'(modify_en), 64'(0));
            chk("stall tag frozen", 64'(alloc_tag), 64'(1));
        end
        cycle(0, 1, 0, 0, '0, 0, 0, 0, 1);
        chk("stall resume modify_en", 64'(modify_en), 64'(1));
        chk("stall resume choice", 64'(choice), 64'(1));
        chk("stall resume clear", 64'(clear), 64'(0));

        // Three mispredicts, with an alloc dropped in the mispredict cycle.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 1, 1, 32'h1000 + 32'(k), 0, 0, 0, 1);
            cycle(0, 1, 0, 0, '0, 1, 0, 0, 1);
            cycle(0, 1, 1, 0, 32'hBAD, 0, 0, 0, 1);
            chk("mis redirect_pc", 64'(redirect_pc), 64'(32'h1000 + 32'(k)));
            chk("mis flush alloc_ready", 64'(alloc_ready), 64'(0));
            cycle(0, 1, 0, 0, '0, 0, 0, 0, 1);
            chk("mis recover tag", 64'(alloc_tag), 64'(0));
        end
        chk("mispredict_cnt 3", 64'(mispredict_cnt), STATS ? 64'(3) : 64'(0));

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit rs, rv, ae, ap, re, rk;
            int rt;
            rs = ($urandom_range(199, 0) == 0);
            rv = ($urandom_range(9, 0) != 0);
            ae = ($urandom_range(9, 0) < 6);
            ap = 1'($urandom_range(1, 0));
            re = 1'($urandom_range(1, 0));
            if (m_count > 0 && $urandom_range(3, 0) != 0)
                rt = (m_head + int'($urandom_range(m_count - 1, 0))) % D;
            else
                rt = int'($urandom_range(D - 1, 0));
            rk = ($urandom_range(99, 0) < 85) ? m_p[rt] : !m_p[rt];
            cycle(rs, rv, ae, ap, $urandom, re, rt, rk, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_tracker.md
BRANCH_TRACKER -- requirements
Module: branch_tracker

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the width of PC values.
REQ-002 SHALL have parameter DEPTH_LOG2, default 3, giving 8 in-flight branch entries.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rdy  input  1  global enable; when low, all state is frozen.
REQ-006 SHALL have port alloc_en  input  1  fetch allocates an entry for a predicted branch.
REQ-007 SHALL have port alloc_pred  input  1  predicted direction (1 = taken).
REQ-008 SHALL have port alloc_alt_pc  input  ADDR_WIDTH  recovery PC used if the prediction is wrong.
REQ-009 SHALL have port alloc_ready  output  1  high when an entry can be accepted.
REQ-010 SHALL have port alloc_tag  output  DEPTH_LOG2  tag assigned to an allocation this cycle (the tail index).
REQ-011 SHALL have port resolve_en  input  1  execute unit reports an outcome.
REQ-012 SHALL have port resolve_tag  input  DEPTH_LOG2  entry being resolved.
REQ-013 SHALL have port resolve_taken  input  1  actual direction.
REQ-014 SHALL have port modify_en  output  1  one-cycle pulse: predictor history update.
REQ-015 SHALL have port clear  output  1  with modify_en: misprediction, and the predictor restores history.
REQ-016 SHALL have port choice  output  1  with modify_en: actual direction.
REQ-017 SHALL have port redirect_en  output  1  one-cycle pulse to PC unit.
REQ-018 SHALL have port redirect_pc  output  ADDR_WIDTH  target PC, valid with redirect_en.
REQ-019 SHALL have port mispredict_cnt  output  16  misprediction count (see Configuration).

Function
REQ-020 SHALL keep a circular queue of 2^DEPTH_LOG2 entries {valid, resolved, pred, taken, alt_pc} with head and tail pointers and a count register; pointers wrap modulo depth.
REQ-021 SHALL drive alloc_ready = (state==RUN) && (count < depth), computed from start-of-cycle state; a commit in the same cycle does not raise alloc_ready.
REQ-022 SHALL write entry[tail] and increment tail when alloc_en && alloc_ready && rdy; alloc_en with alloc_ready low is ignored.
REQ-023 SHALL set entry[resolve_tag] resolved/taken on resolve_en; it ignores a resolve to an invalid entry or to an already-resolved entry.
REQ-024 SHALL evaluate commit from registered flags only, so a head entry resolved in cycle N commits at the earliest in cycle N+1.
REQ-025 SHALL, on commit of a correct head entry (taken==pred), pulse modify_en=1, clear=0, choice=taken in the next cycle, invalidate the head and increment it.
REQ-026 SHALL, on commit of a mispredicted head, pulse modify_en=1, clear=1, choice=taken, redirect_en=1, and redirect_pc=alt_pc in the next cycle, invalidate all entries, set head=tail=count=0, and enter FLUSH.
REQ-027 SHALL use FSM states RUN and FLUSH: RUN->FLUSH on a mispredict commit; FLUSH->RUN after exactly one cycle; in FLUSH, alloc_ready=0 and allocation and resolution are ignored.
REQ-028 SHALL drop an allocation or resolution arriving in the same cycle as a mispredict commit.
REQ-029 SHALL handle alloc, resolve, and correct commit in one cycle independently; count changes by (+1 alloc) + (-1 commit).
REQ-030 SHALL commit at most one entry per cycle.
REQ-031 SHALL register all pulse outputs and force them to 0 in any cycle rdy is low.

Reset
REQ-032 SHALL, on rst, clear all valid bits, head/tail/count=0, state=RUN, modify_en=clear=choice=redirect_en=0, redirect_pc=0, and mispredict_cnt=0; rst overrides rdy and aborts a FLUSH.

Configuration
REQ-033 SHALL, with BRANCH_TRACKER_STATS_EN defined, increment mispredict_cnt on each mispredict commit, saturating at 16'hFFFF; without it, mispredict_cnt is tied to 0 and no counter is built.

Verification
REQ-034 Reset, then alloc pred=1 as tag 0, resolve tag 0 taken=1 -> one cycle later modify_en=1, clear=0, choice=1, redirect_en=0.
REQ-035 Alloc pred=1 with alt_pc=0x100, resolve taken=0 -> modify_en=1, clear=1, choice=0, redirect_en=1, redirect_pc=0x100; next cycle alloc_ready=0; the cycle after, alloc_ready=1 and count=0.
REQ-036 Fill 8 entries -> alloc_ready=0, and a 9th alloc_en is ignored; resolve tag 0 -> after commit alloc_ready=1, and the next alloc gets tag 0 (wrap).
REQ-037 Resolve tag 1 before tag 0 -> no commit; resolve tag 0 -> commits of tag 0 and tag 1 on consecutive cycles.
REQ-038 rdy=0 during a pending commit -> no pulses and no state change; rdy=1 -> the commit completes unchanged.
REQ-039 With BRANCH_TRACKER_STATS_EN, run 3 mispredicts -> mispredict_cnt=3; without it, mispredict_cnt=0.
